// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and line levels.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;
  localparam logic UART_STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud down-counter: reloads to BITPERIOD-1 on restart and flags bit_end at zero.
module uart_baud_gen #(
  parameter int BITPERIOD = 434
) (
  input  logic clk50m,
  input  logic rst,
  input  logic restart,
  output logic bit_end
);

  localparam int CW = $clog2(BITPERIOD);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk50m) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= CW'(BITPERIOD - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign bit_end = (cnt == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, WIDTH data bits LSB-first, stop bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int FCLK  = 50000000,
  parameter int FBAUD = 115200
) (
  input  logic             clk50m,
  input  logic             rst,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx,
  output logic             tx_idle,
  output logic             tx_done
);

  localparam int BITPERIOD = FCLK / FBAUD;
  localparam int BCW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (BITPERIOD < 2) begin : g_bad_bitperiod
    $error("uart_tx: FCLK/FBAUD must be at least 2");
  end

  tx_state_t        state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic [BCW-1:0]   bit_cnt;
  logic             bit_end;
  logic             restart;
  logic             xfer;
`ifdef UART_TX_PARITY_EN
  logic             parity_bit;
`endif

  assign tx_ready   = (state == IDLE) && !rst;
  assign xfer       = tx_valid && tx_ready;
  assign shreg_next = shreg >> 1;
  // Every bit boundary, including the first one after a handshake, reloads the baud counter.
  assign restart    = xfer || ((state != IDLE) && bit_end);
  assign tx_done    = (state == STOP) && bit_end;

  uart_baud_gen #(
    .BITPERIOD(BITPERIOD)
  ) u_baud (
    .clk50m (clk50m),
    .rst    (rst),
    .restart(restart),
    .bit_end(bit_end)
  );

  always_ff @(posedge clk50m) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= UART_IDLE_LEVEL;
      tx_idle <= 1'b1;
      bit_cnt <= '0;
      shreg   <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            shreg   <= tx_data;
            tx      <= UART_START_LEVEL;
            tx_idle <= 1'b0;
            state   <= START;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^tx_data;
`endif
          end
        end
        START: begin
          if (bit_end) begin
            bit_cnt <= '0;
            tx      <= shreg[0];
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt == BCW'(WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
              tx    <= parity_bit;
              state <= PARITY;
`else
              tx    <= UART_STOP_LEVEL;
              state <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= shreg_next;
              tx      <= shreg_next[0];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            tx    <= UART_STOP_LEVEL;
            state <= STOP;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            tx      <= UART_IDLE_LEVEL;
            tx_idle <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          tx      <= UART_IDLE_LEVEL;
          tx_idle <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter: the stage directly upstream of `uart_rx` on the serial line. It accepts a parallel `WIDTH`-bit word over a valid/ready handshake and serialises it as one frame on `tx`: start bit, data LSB-first, optional even parity, stop bit. It drives the same line format that `uart_rx` expects, so the pair can be looped back on a board or in a bench.

## Interface

Parameters:
- `WIDTH`, 8: data bits per frame.
- `FCLK`, 50000000: clock frequency in Hz.
- `FBAUD`, 115200: baud rate in bit/s.

Ports:
- `clk50m`, input, 1: system clock. This is the only clock.
- `rst`, input, 1: synchronous reset, active-high.
- `tx_data`, input, `WIDTH`: word to send. Sampled only on handshake.
- `tx_valid`, input, 1: `tx_data` is valid.
- `tx_ready`, output, 1: block can accept a word.
- `tx`, output, 1: serial line, registered. Idle level is 1.
- `tx_idle`, output, 1: high while no frame is in progress.
- `tx_done`, output, 1: one-cycle pulse when a frame's stop bit completes.

## Operation

- `BITPERIOD = FCLK/FBAUD`, truncated. At the defaults this is 434 cycles.
  - Elaboration fails if `BITPERIOD < 2`.
- Baud counter:
  - Width is `$clog2(BITPERIOD)`.
  - Loaded with `BITPERIOD-1` on each bit start and counts down to 0.
  - Bit end occurs when the counter is 0.
- Bit counter width is `$clog2(WIDTH)`. It indexes data bits 0 to `WIDTH-1`.
- Handshake:
  - A transfer occurs on a clock edge where `tx_valid && tx_ready`.
  - `tx_ready = (state==IDLE) && !rst`, combinational.
  - On transfer, `tx_data` is copied into an internal shift register.
  - `tx_data` and `tx_valid` are ignored at all other times.
- FSM states are IDLE, START, DATA, PARITY, STOP:
  - IDLE: `tx`=1, `tx_idle`=1. On transfer, go to START.
  - START: `tx`=0 for `BITPERIOD` cycles, then go to DATA with bit counter 0.
  - DATA: `tx`=shreg[0] for `BITPERIOD` cycles.
    - At bit end, shift right and increment the bit counter.
    - After bit `WIDTH-1`, go to PARITY if `UART_TX_PARITY_EN` is defined, otherwise go to STOP.
  - PARITY: `tx` = XOR of the captured word, for `BITPERIOD` cycles. Then go to STOP.
  - STOP: `tx`=1 for `BITPERIOD` cycles. At bit end, pulse `tx_done` and go to IDLE.
  - Illegal state: go to IDLE.
- Reset values, after the first edge with `rst`=1:
  - state IDLE, `tx`=1, `tx_idle`=1, `tx_done`=0, counters 0.
  - `tx_ready` is 0 while `rst` is high and 1 after release.
- Reset mid-frame aborts the frame:
  - `tx` returns to 1 after the reset edge.
  - No `tx_done` pulse is issued.
  - The truncated frame on the line is acceptable.

## Timing

- Latency: the falling edge of `tx` (start bit) appears on the edge after the handshake edge.
- Each bit lasts exactly `BITPERIOD` cycles. `tx` changes only at bit boundaries.
- Frame length:
  - (`WIDTH`+2)·`BITPERIOD` cycles without parity.
  - (`WIDTH`+3)·`BITPERIOD` cycles with parity.
- `tx_done` is high for the single cycle in which STOP ends.
- `tx_ready` rises on the cycle after `tx_done`.
- Back-to-back transfers (`tx_valid` held high):
  - The next handshake happens in the first IDLE cycle.
  - This gives a 1-cycle idle gap, so consecutive start edges are exactly frame length + 1 cycles apart.
- `tx_valid` asserted during a frame stalls until IDLE. No word is lost or duplicated.

## Configuration

- `UART_TX_PARITY_EN` defined:
  - PARITY state is compiled in.
  - An even-parity bit is sent between the last data bit and the stop bit.
- `UART_TX_PARITY_EN` not defined:
  - PARITY state and XOR logic are absent.
  - DATA goes directly to STOP and the frame is 10 bits at `WIDTH`=8.

## Structure

- `uart_pkg` holds:
  - `tx_state_t`, the enum IDLE/START/DATA/PARITY/STOP.
  - `UART_IDLE_LEVEL = 1'b1`, `UART_START_LEVEL = 1'b0`, `UART_STOP_LEVEL = 1'b1`.
- Parameter-derived constants (`BITPERIOD`, counter widths) stay local to the module.
- One sub-module, `uart_baud_gen`:
  - Contains the baud down-counter.
  - Inputs: `clk50m`, `rst`, `restart`.
  - Output: `bit_end`.
  - Parameter: `BITPERIOD`.
  - `uart_rx` can adopt it later.

## Test plan

All scenarios use `FCLK`=1000000 and `FBAUD`=100000, so `BITPERIOD`=10.

1. Reset: `rst`=1 for 3 cycles, then 0 → during reset `tx`=1, `tx_done`=0, `tx_ready`=0; after release `tx_ready`=1 and `tx_idle`=1.
2. Single frame: `tx_data`=0xA5 with one-cycle `tx_valid`, no parity → `tx`=0 for 10 cycles, then 1,0,1,0,0,1,0,1 for 10 cycles each, then 1 for 10 cycles; `tx_done` pulses 100 cycles after the start edge.
3. Back-to-back: 0x00 then 0xFF with `tx_valid` held → second start edge exactly 101 cycles after the first; bits match; two `tx_done` pulses.
4. Busy stall: toggle `tx_data` while `tx_valid`=1 during frame 0x3C → `tx_ready`=0 throughout; the line carries 0x3C unchanged; the next word is taken only after `tx_done`.
5. Reset during data bit 3 of 0xFF → `tx`=1 on the edge after reset; no `tx_done`; the next accepted 0x81 is sent as a complete, correct frame.
6. With `UART_TX_PARITY_EN` defined, send 0x07 → parity bit 1 after bit 7; frame is 110 cycles; `tx_done` pulses at cycle 110. With 0x03, the parity bit is 0.
